fib_seg_display: RTL

Downstream display stage for the Fibonacci counter. It takes the counter's 6-bit binary output and converts it to two BCD digits with a sequential double-dabble engine. It then drives a time-multiplexed, active-low two-digit 7-segment display with the result. The block sits between the counter's `aout` bus and the board's `seg`/`an` pins.

---
 rtl/fib_seg_display.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/fib_seg_display.sv
// fib_seg_display: binary-to-BCD (sequential double dabble) plus a
// two-digit active-low multiplexed 7-segment driver.
// Ports: clk, reset (async, active-high), value[5:0] in;
// seg[6:0] {g..a}, an[3:0], dp, busy out (all active-low except busy).
// Build option: FIB_SEG_BLANK_LEADING_ZERO_EN blanks a zero tens digit.
module fib_seg_display #(
  parameter int REFRESH_BITS = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] value,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    LOAD
  } state_t;

  state_t state, state_d;

  logic [5:0]  src, src_d;
  logic [13:0] sh, sh_d, sh_adj;
  logic [2:0]  iter, iter_d;
  logic [3:0]  tens_q, tens_d;
  logic [3:0]  units_q, units_d;
  logic        busy_d;

  logic [REFRESH_BITS-1:0] rcnt;
  logic                    sel;
  logic                    blank;
  logic [3:0]              digit;
  logic [6:0]              seg_d;
  logic [3:0]              an_d;

  function automatic logic [6:0] dec(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Add-3 correction on each BCD nibble before the shift.
  always_comb begin
    sh_adj = sh;
    if (sh[13:10] >= 4'd5)
      sh_adj[13:10] = sh[13:10] + 4'd3;
    if (sh[9:6] >= 4'd5)
      sh_adj[9:6] = sh[9:6] + 4'd3;
  end

  always_comb begin
    state_d = state;
    src_d   = src;
    sh_d    = sh;
    iter_d  = iter;
    tens_d  = tens_q;
    units_d = units_q;
    busy_d  = busy;
    unique case (state)
      IDLE: begin
        if (value != src) begin
          src_d   = value;
          sh_d    = {8'b0, value};
          iter_d  = 3'd0;
          busy_d  = 1'b1;
          state_d = CONV;
        end
      end
      CONV: begin
        sh_d   = {sh_adj[12:0], 1'b0};
        iter_d = iter + 3'd1;
        if (iter == 3'd5)
          state_d = LOAD;
      end
      LOAD: begin
        tens_d  = sh[13:10];
        units_d = sh[9:6];
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      src     <= '0;
      sh      <= '0;
      iter    <= '0;
      tens_q  <= '0;
      units_q <= '0;
      busy    <= 1'b0;
    end else begin
      state   <= state_d;
      src     <= src_d;
      sh      <= sh_d;
      iter    <= iter_d;
      tens_q  <= tens_d;
      units_q <= units_d;
      busy    <= busy_d;
    end
  end

  // Display path: select from the current rcnt MSB, so an/seg
  // trail the select bit by one cycle and switch together.
  assign sel   = rcnt[REFRESH_BITS-1];
  assign digit = sel ? tens_q : units_q;

`ifdef FIB_SEG_BLANK_LEADING_ZERO_EN
  assign blank = sel && (tens_q == 4'd0);
`else
  assign blank = 1'b0;
`endif

  assign seg_d = blank ? 7'b1111111 : dec(digit);
  assign an_d  = sel ? 4'b1101 : 4'b1110;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rcnt <= '0;
      seg  <= 7'b1000000;
      an   <= 4'b1110;
    end else begin
      rcnt <= rcnt + 1'b1;
      seg  <= seg_d;
      an   <= an_d;
    end
  end

  assign dp = 1'b1;

endmodule
